// File: rtl/psg_stereo_mixer.sv
// -----------------------------------------------------------------------------
// psg_stereo_mixer
//
// Sequential stereo mixer for NUM_CHIPS three-voice PSG chips. One request on
// sample_stb_i snapshots every channel sample together with the per-channel
// gain/pan settings. The block then walks the channels one per clock,
// accumulating (sample*gain)>>2 into the left and/or right accumulator. It
// then saturates both sums to OUT_WIDTH bits and presents them with a
// one-cycle valid_o pulse. Latency from strobe to valid_o is NCH+1 clocks.
//
// Configuration macro:
//   PSG_MIXER_PAN_EN  defined   -> pan bits cfg_data_i[5:4] are writable.
//                     undefined -> pan is fixed: even chips left-only,
//                                  odd chips right-only. Gain stays writable.
//
// Parameters:
//   NUM_CHIPS  number of PSG chips mixed (1..4), NCH = 3*NUM_CHIPS channels
//   CH_WIDTH   width of each unsigned channel sample
//   OUT_WIDTH  width of each unsigned stereo output
//
// Ports:
//   clk_logic     clock, all state updates on the rising edge
//   reset         synchronous active-high reset, highest priority
//   chan_i        channel samples, channel 0 in the LSBs (chip k/3, voice k%3)
//   sample_stb_i  single-cycle request to mix one output sample
//   cfg_we_i      configuration write strobe
//   cfg_addr_i    channel index of the write (indices >= NCH are ignored)
//   cfg_data_i    [3:0] gain, [4] left enable, [5] right enable
//   clip_clr_i    clears the sticky clip flag (a simultaneous set wins)
//   audio_l_o     mixed left sample, held between valid_o pulses
//   audio_r_o     mixed right sample, held between valid_o pulses
//   valid_o       one-cycle pulse when audio_l_o/audio_r_o carry a new result
//   busy_o        high while a mix is in progress
//   missed_o      one-cycle pulse when a strobe arrives while busy
//   clip_o        sticky saturation flag
// -----------------------------------------------------------------------------
module psg_stereo_mixer #(
    parameter int NUM_CHIPS = 2,
    parameter int CH_WIDTH  = 8,
    parameter int OUT_WIDTH = 10
) (
    input  logic                            clk_logic,
    input  logic                            reset,
    input  logic [NUM_CHIPS*3*CH_WIDTH-1:0] chan_i,
    input  logic                            sample_stb_i,
    input  logic                            cfg_we_i,
    input  logic [3:0]                      cfg_addr_i,
    input  logic [7:0]                      cfg_data_i,
    input  logic                            clip_clr_i,
    output logic [OUT_WIDTH-1:0]            audio_l_o,
    output logic [OUT_WIDTH-1:0]            audio_r_o,
    output logic                            valid_o,
    output logic                            busy_o,
    output logic                            missed_o,
    output logic                            clip_o
);

    localparam int NCH       = NUM_CHIPS * 3;
    localparam int IDX_W     = $clog2(NCH);
    localparam int PROD_W    = CH_WIDTH + 4;
    localparam int CONTRIB_W = CH_WIDTH + 2;
    // One spare bit beyond the worst-case sum of NCH contributions.
    localparam int ACC_W     = CONTRIB_W + $clog2(NCH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Gain 4 is unity: the product is shifted right by two.
    function automatic logic [CONTRIB_W-1:0] scale_contrib(
        input logic [CH_WIDTH-1:0] smp,
        input logic [3:0]          gain
    );
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(smp) * PROD_W'(gain);
        return prod[PROD_W-1:2];
    endfunction

    function automatic logic is_over(input logic [ACC_W-1:0] acc);
        return (ACC_W > OUT_WIDTH) && ((acc >> OUT_WIDTH) != '0);
    endfunction

    function automatic logic [OUT_WIDTH-1:0] sat_out(input logic [ACC_W-1:0] acc);
        if (is_over(acc)) begin
            return '1;
        end
        return OUT_WIDTH'(acc);
    endfunction

    // Pan is {R,L}: even chips default to the left, odd chips to the right.
    function automatic logic [1:0] pan_reset_val(input int k);
        return (((k / 3) % 2) == 0) ? 2'b01 : 2'b10;
    endfunction

    state_t               state_q;
    state_t               state_d;
    logic [IDX_W-1:0]     idx_q;
    logic                 last_ch;

    logic [3:0]           gain_q [NCH];
    logic [1:0]           pan_q  [NCH];

    logic [NCH*CH_WIDTH-1:0] chan_s;
    logic [3:0]           gain_s [NCH];
    logic [1:0]           pan_s  [NCH];

    logic [CH_WIDTH-1:0]  cur_smp;
    logic [CONTRIB_W-1:0] contrib;
    logic [ACC_W-1:0]     acc_l_q;
    logic [ACC_W-1:0]     acc_r_q;
    logic [ACC_W-1:0]     acc_l_d;
    logic [ACC_W-1:0]     acc_r_d;

    logic [OUT_WIDTH-1:0] audio_l_q;
    logic [OUT_WIDTH-1:0] audio_r_q;
    logic                 clip_q;

    assign last_ch = (state_q == S_ACCUM) && (idx_q == IDX_W'(NCH - 1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_logic) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sample_stb_i) state_d = S_ACCUM;
            S_ACCUM: if (last_ch)      state_d = S_DONE;
            S_DONE:                    state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // Reset gates the pulses so an aborted mix never shows valid_o.
    always_comb begin
        busy_o   = (state_q != S_IDLE);
        valid_o  = (state_q == S_DONE) && !reset;
        missed_o = sample_stb_i && (state_q != S_IDLE) && !reset;
    end

    // ------------------------------------------------- configuration regs
    always_ff @(posedge clk_logic) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                gain_q[k] <= 4'd4;
            end
        end else if (cfg_we_i) begin
            // Full 4-bit compare: out-of-range addresses match nothing.
            for (int k = 0; k < NCH; k++) begin
                if (cfg_addr_i == 4'(k)) begin
                    gain_q[k] <= cfg_data_i[3:0];
                end
            end
        end
    end

`ifdef PSG_MIXER_PAN_EN
    always_ff @(posedge clk_logic) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                pan_q[k] <= pan_reset_val(k);
            end
        end else if (cfg_we_i) begin
            for (int k = 0; k < NCH; k++) begin
                if (cfg_addr_i == 4'(k)) begin
                    pan_q[k] <= cfg_data_i[5:4];
                end
            end
        end
    end

    logic unused_cfg;
    assign unused_cfg = &{1'b0, cfg_data_i[7:6]};
`else
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            pan_q[k] = pan_reset_val(k);
        end
    end

    logic unused_cfg;
    assign unused_cfg = &{1'b0, cfg_data_i[7:4]};
`endif

    // ------------------------------------------------ snapshot and index
    // The mix reads only the snapshot, so config writes mid-mix affect
    // the following sample only.
    always_ff @(posedge clk_logic) begin
        if (state_q == S_IDLE && sample_stb_i) begin
            chan_s <= chan_i;
            gain_s <= gain_q;
            pan_s  <= pan_q;
        end
    end

    always_ff @(posedge clk_logic) begin
        if (reset) begin
            idx_q <= '0;
        end else if (state_q == S_IDLE && sample_stb_i) begin
            idx_q <= '0;
        end else if (state_q == S_ACCUM && !last_ch) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    // ---------------------------------------------------------- accumulate
    always_comb begin
        cur_smp = chan_s[int'(idx_q) * CH_WIDTH +: CH_WIDTH];
        contrib = scale_contrib(cur_smp, gain_s[idx_q]);
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        if (pan_s[idx_q][0]) acc_l_d = acc_l_q + ACC_W'(contrib);
        if (pan_s[idx_q][1]) acc_r_d = acc_r_q + ACC_W'(contrib);
    end

    always_ff @(posedge clk_logic) begin
        if (state_q == S_IDLE && sample_stb_i) begin
            acc_l_q <= '0;
            acc_r_q <= '0;
        end else if (state_q == S_ACCUM) begin
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
        end
    end

    // ------------------------------------------------------ output stage
    // Results load on the edge that enters DONE, so they are already valid
    // during the DONE cycle when valid_o pulses.
    always_ff @(posedge clk_logic) begin
        if (reset) begin
            audio_l_q <= '0;
            audio_r_q <= '0;
            clip_q    <= 1'b0;
        end else begin
            if (last_ch) begin
                audio_l_q <= sat_out(acc_l_d);
                audio_r_q <= sat_out(acc_r_d);
            end
            if (last_ch && (is_over(acc_l_d) || is_over(acc_r_d))) begin
                clip_q <= 1'b1;
            end else if (clip_clr_i) begin
                clip_q <= 1'b0;
            end
        end
    end

    assign audio_l_o = audio_l_q;
    assign audio_r_o = audio_r_q;
    assign clip_o    = clip_q;

endmodule

// File: doc/psg_stereo_mixer.md
PSG_STEREO_MIXER -- requirements
Module: psg_stereo_mixer

Interface
REQ-001 The block SHALL have parameter NUM_CHIPS, default 2, meaning the number of PSG chips mixed, legal range 1..4.
REQ-002 The block SHALL have parameter CH_WIDTH, default 8, meaning the width of each unsigned channel sample.
REQ-003 The block SHALL have parameter OUT_WIDTH, default 10, meaning the width of each unsigned stereo output.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port clk_logic, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port chan_i, input, NUM_CHIPS*3*CH_WIDTH bits: channel samples; channel k = chip k/3, voice k%3 (A,B,C); channel 0 in the LSBs.
REQ-008 The block SHALL have port sample_stb_i, input, 1 bit: a single-cycle request to mix one output sample.
REQ-009 The block SHALL have port cfg_we_i, input, 1 bit: configuration write strobe.
REQ-010 The block SHALL have port cfg_addr_i, input, 4 bits: channel index of the configuration write.
REQ-011 The block SHALL have port cfg_data_i, input, 8 bits: [3:0] gain, [4] left enable, [5] right enable; [7:6] are ignored.
REQ-012 The block SHALL have port clip_clr_i, input, 1 bit: clears clip_o.
REQ-013 The block SHALL have ports audio_l_o and audio_r_o, outputs, OUT_WIDTH bits each: the mixed left and right samples.
REQ-014 The block SHALL have port valid_o, output, 1 bit: a one-cycle pulse when audio_l_o and audio_r_o update.
REQ-015 The block SHALL have port busy_o, output, 1 bit: high while a mix is in progress.
REQ-016 The block SHALL have port missed_o, output, 1 bit: a one-cycle pulse when a strobe arrives while busy.
REQ-017 The block SHALL have port clip_o, output, 1 bit: sticky saturation flag.

Function
REQ-018 The block SHALL define NCH = NUM_CHIPS*3 channels, each with a 4-bit gain register and a 2-bit pan register {R,L}.
REQ-019 A write with cfg_we_i=1 and cfg_addr_i<NCH SHALL update that channel's gain and pan on the next edge; a write with cfg_addr_i>=NCH SHALL be ignored.
REQ-020 The state machine SHALL have three states: IDLE, ACCUM and DONE.
REQ-021 In IDLE with sample_stb_i=1 (cycle 0), the block SHALL snapshot chan_i and all gain/pan registers, clear both accumulators, set the channel index to 0 and enter ACCUM.
REQ-022 In ACCUM, the block SHALL process one channel per cycle: contribution = (sample*gain)>>2, i.e. a 12-bit product truncated to 10 bits, so gain 4 = unity and gain 15 = 3.75x.
REQ-023 In ACCUM, the contribution SHALL be added to the left accumulator when L=1 and to the right accumulator when R=1; pan 00 mutes the channel.
REQ-024 Accumulators SHALL be wide enough never to wrap: at least 10+clog2(NCH)+1 bits.
REQ-025 After channel NCH-1 is processed, the block SHALL enter DONE; ACCUM therefore occupies cycles 1..NCH.
REQ-026 In DONE (cycle NCH+1), each output SHALL load min(acc, 2^OUT_WIDTH-1), valid_o SHALL pulse for that one cycle, and the state SHALL return to IDLE.
REQ-027 The total latency SHALL be NCH+1 cycles from strobe to valid_o, so back-to-back strobes are accepted at most once every NCH+2 cycles.
REQ-028 busy_o SHALL be 1 in ACCUM and DONE and 0 in IDLE.
REQ-029 A sample_stb_i that arrives in ACCUM or DONE SHALL be dropped, and missed_o SHALL pulse in that cycle.
REQ-030 Configuration writes during ACCUM or DONE SHALL update the registers but SHALL NOT affect the mix in progress, because the mix uses the snapshot.
REQ-031 When either output saturates in DONE, clip_o SHALL be set.
REQ-032 clip_clr_i SHALL clear clip_o; if saturation and clip_clr_i occur in the same cycle, the set SHALL win.
REQ-033 audio_l_o and audio_r_o SHALL hold their value between valid_o pulses.

Reset
REQ-034 Reset SHALL have priority over all other inputs.
REQ-035 On reset, the state SHALL be IDLE, and audio_l_o, audio_r_o, valid_o, busy_o, missed_o and clip_o SHALL all be 0.
REQ-036 On reset, every gain register SHALL be 4.
REQ-037 On reset, the pan of even-numbered chips SHALL be L-only (01) and the pan of odd-numbered chips SHALL be R-only (10).
REQ-038 A reset asserted during ACCUM or DONE SHALL abort the mix: no valid_o pulse, and the outputs go to 0.

Configuration
REQ-039 With macro PSG_MIXER_PAN_EN defined, the pan bits SHALL be writable per REQ-019.
REQ-040 Without PSG_MIXER_PAN_EN, the pan registers SHALL be constant at their REQ-037 reset values, cfg_data_i[5:4] SHALL be ignored, and gain SHALL remain writable.

Verification
REQ-041 Defaults, NUM_CHIPS=2: chip0 A/B/C=255, chip1 A/B/C=16, one strobe -> valid_o exactly 7 cycles later, audio_l_o=765, audio_r_o=48, clip_o=0.
REQ-042 Saturation: all six channels=255, all gains=15, every pan=11 (macro on) -> both outputs=1023, clip_o=1 until clip_clr_i, then clip_o=0.
REQ-043 Strobe overlap: a strobe at cycle 0 and again at cycle 3 -> missed_o pulses at cycle 3, exactly one valid_o at cycle 7; a strobe at cycle 8 is accepted.
REQ-044 Mid-mix config: a gain write of 0 to channel 0 at cycle 2 -> the current result uses gain 4, and the next sample uses gain 0.
REQ-045 Reset mid-mix: reset at cycle 4 -> no valid_o, outputs=0, busy_o=0 the next cycle.
REQ-046 Macro off: write 0x34 to channel 0 -> the gain changes to 4 and the pan stays 01; channel 0 still mixes left only.
